// File: rtl/mem_responder.sv
// mem_responder: byte-wide memory target with programmable wait states, range checking, access counters and a loader port.
module mem_responder #(
   parameter int ADDR_BITS   = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 m_req,
   input  logic                 m_wr,
   input  logic [15:0]          m_addr,
   input  logic [7:0]           m_outdata,
   output logic                 m_wait,
   output logic [7:0]           m_indata,
   output logic                 bus_err,
   output logic [15:0]          rd_count,
   output logic [15:0]          wr_count,
   input  logic                 ld_we,
   input  logic [ADDR_BITS-1:0] ld_addr,
   input  logic [7:0]           ld_data
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
   localparam logic [3:0] CNT_INIT  = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
   localparam logic       ZERO_WAIT = WAIT_CYCLES == 0;
   state_t               state, state_nx;
   logic [3:0]           cnt, cnt_nx;
   logic [7:0]           mem [2**ADDR_BITS];
   logic [ADDR_BITS-1:0] addr;
   logic                 in_range, done;
   assign addr     = m_addr[ADDR_BITS-1:0];
   assign in_range = (m_addr >> ADDR_BITS) == 16'd0;
   assign m_indata = in_range ? mem[addr] : 8'hFF;
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      m_wait   = 1'b0;
      done     = 1'b0;
      if (state == S_IDLE) begin
         m_wait = m_req & ~ZERO_WAIT;
         done   = m_req & ZERO_WAIT;
         if (m_req & ~ZERO_WAIT) begin
            state_nx = S_WAIT;
            cnt_nx   = CNT_INIT;
         end
      end else if (state == S_WAIT) begin
         m_wait = m_req;
         if (!m_req) state_nx = S_IDLE;
         else if (cnt == 4'd0) state_nx = S_DONE;
         else cnt_nx = cnt - 4'd1;
      end else begin
         done     = m_req;
         state_nx = S_IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= 4'd0;
         bus_err  <= 1'b0;
         rd_count <= 16'd0;
         wr_count <= 16'd0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         bus_err <= done & ~in_range;
         if (done & m_wr) wr_count <= wr_count + 16'd1;
         if (done & ~m_wr) rd_count <= rd_count + 16'd1;
      end
   end
   // loader is ungated by reset; a core write to the same byte lands last and wins
   always_ff @(posedge clk) begin
      if (ld_we) mem[ld_addr] <= ld_data;
      if (done & m_wr & in_range & ~rst) mem[addr] <= m_outdata;
   end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder across wait-state settings 0..3.
module tb_mem_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m_req = 1'b0;
   logic        m_wr = 1'b0;
   logic [15:0] m_addr = 16'd0;
   logic [7:0]  m_outdata = 8'd0;
   logic        ld_we = 1'b0;
   logic [7:0]  ld_addr = 8'd0;
   logic [7:0]  ld_data = 8'd0;
   logic        m_wait_v [4];
   logic [7:0]  m_indata_v [4];
   logic        bus_err_v [4];
   logic [15:0] rd_count_v [4];
   logic [15:0] wr_count_v [4];
   int          checks = 0;
   int          errors = 0;
   int          stalls;
   logic [7:0]  rd;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(g)) dut (
         .clk(clk), .rst(rst), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
         .m_outdata(m_outdata), .m_wait(m_wait_v[g]), .m_indata(m_indata_v[g]),
         .bus_err(bus_err_v[g]), .rd_count(rd_count_v[g]), .wr_count(wr_count_v[g]),
         .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_all();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic peek(input int i, input logic [15:0] a, input string tag, input logic [7:0] exp);
      m_addr = a;
      #1;
      chk(tag, {24'd0, m_indata_v[i]}, {24'd0, exp});
   endtask

   // drives one access to completion; reports stall cycles and data seen on the completing cycle
   task automatic access(input int i, input logic w, input logic [15:0] a, input logic [7:0] d,
                         output int n, output logic [7:0] r);
      m_req = 1'b1; m_wr = w; m_addr = a; m_outdata = d;
      n = 0;
      #1;
      while (m_wait_v[i] && n < 20) begin
         n++;
         @(posedge clk);
         #2;
      end
      if (n >= 20) chk("stall_timeout", 32'(n), 32'd0);
      r = m_indata_v[i];
      tick();
      m_req = 1'b0;
   endtask

   initial begin
      // preload everything to zero except bytes 0..2, all while in reset
      ld_we = 1'b1;
      for (int a = 0; a < 256; a++) begin
         ld_addr = 8'(a);
         ld_data = (a == 0) ? 8'h10 : (a == 1) ? 8'h55 : (a == 2) ? 8'hAA : 8'h00;
         tick();
      end
      ld_we = 1'b0;
      rst = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst_rd_count%0d", i), 32'(rd_count_v[i]), 32'd0);
         chk($sformatf("rst_bus_err%0d", i), 32'(bus_err_v[i]), 32'd0);
      end
      peek(0, 16'd2, "ld_during_rst", 8'hAA);

      // 1: zero-wait read
      reset_all();
      access(0, 1'b0, 16'd1, 8'h00, stalls, rd);
      chk("t1_stalls", 32'(stalls), 32'd0);
      chk("t1_data", 32'(rd), 32'h55);
      chk("t1_rd_count", 32'(rd_count_v[0]), 32'd1);

      // 2: two wait states, write then read back
      reset_all();
      access(2, 1'b1, 16'd5, 8'h3C, stalls, rd);
      chk("t2_wr_stalls", 32'(stalls), 32'd3);
      access(2, 1'b0, 16'd5, 8'h00, stalls, rd);
      chk("t2_rd_stalls", 32'(stalls), 32'd3);
      chk("t2_rd_data", 32'(rd), 32'h3C);
      chk("t2_wr_count", 32'(wr_count_v[2]), 32'd1);
      chk("t2_rd_count", 32'(rd_count_v[2]), 32'd1);

      // 3: out-of-range read and write
      reset_all();
      access(1, 1'b0, 16'h0100, 8'h00, stalls, rd);
      chk("t3_rd_stalls", 32'(stalls), 32'd2);
      chk("t3_oor_data", 32'(rd), 32'hFF);
      chk("t3_bus_err_pulse", 32'(bus_err_v[1]), 32'd1);
      tick();
      chk("t3_bus_err_clear", 32'(bus_err_v[1]), 32'd0);
      chk("t3_rd_count", 32'(rd_count_v[1]), 32'd1);
      access(1, 1'b1, 16'h0100, 8'h77, stalls, rd);
      chk("t3_wr_bus_err", 32'(bus_err_v[1]), 32'd1);
      chk("t3_wr_count", 32'(wr_count_v[1]), 32'd1);
      peek(1, 16'd0, "t3_ram0_kept", 8'h10);

      // 4: reset mid-access
      reset_all();
      m_req = 1'b1; m_wr = 1'b1; m_addr = 16'd7; m_outdata = 8'h99;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; m_req = 1'b0;
      peek(3, 16'd7, "t4_ram7_kept", 8'h00);
      chk("t4_wr_count", 32'(wr_count_v[3]), 32'd0);
      access(3, 1'b0, 16'd7, 8'h00, stalls, rd);
      chk("t4_stalls_after_rst", 32'(stalls), 32'd4);
      chk("t4_rd_data", 32'(rd), 32'h00);

      // 5: core vs loader on the same edge
      reset_all();
      m_req = 1'b1; m_wr = 1'b1; m_addr = 16'd9; m_outdata = 8'h11;
      ld_we = 1'b1; ld_addr = 8'd9; ld_data = 8'h22;
      tick();
      m_req = 1'b0; ld_we = 1'b0;
      peek(0, 16'd9, "t5_core_wins", 8'h11);
      m_req = 1'b1; m_wr = 1'b1; m_addr = 16'd9; m_outdata = 8'h11;
      ld_we = 1'b1; ld_addr = 8'd10; ld_data = 8'h22;
      tick();
      m_req = 1'b0; ld_we = 1'b0;
      peek(0, 16'd9, "t5_core_byte", 8'h11);
      peek(0, 16'd10, "t5_loader_byte", 8'h22);

      // 6: abandoned access, then counter wrap
      reset_all();
      m_req = 1'b1; m_wr = 1'b1; m_addr = 16'd2; m_outdata = 8'hEE;
      tick();
      m_req = 1'b0;
      tick();
      peek(1, 16'd2, "t6_no_commit", 8'hAA);
      chk("t6_wr_count", 32'(wr_count_v[1]), 32'd0);
      access(1, 1'b0, 16'd2, 8'h00, stalls, rd);
      chk("t6_idle_stalls", 32'(stalls), 32'd2);
      chk("t6_rd_count", 32'(rd_count_v[1]), 32'd1);
      reset_all();
      m_req = 1'b1; m_wr = 1'b0; m_addr = 16'd0;
      repeat (65535) tick();
      chk("t6_rd_ffff", 32'(rd_count_v[0]), 32'hFFFF);
      tick();
      m_req = 1'b0;
      chk("t6_rd_wrap", 32'(rd_count_v[0]), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
